// File: rtl/fir_output_capture.sv
// fir_output_capture: drops skip_len leading FIR samples, captures the next DEPTH
// samples into a buffer, and serves them back through a registered read port.
module fir_output_capture #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       skip_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   capture_count,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state, state_n;
    logic [15:0]       skip_cnt, skip_n;
    logic [ADDR_W:0]   count_n;
    logic              wr_en;
    logic [DATA_W-1:0] mem [DEPTH];

    assign busy = (state == SKIP) || (state == CAPTURE);
    assign done = state == DONE;

    always_comb begin
        state_n = state;
        skip_n  = skip_cnt;
        count_n = capture_count;
        wr_en   = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    skip_n  = skip_len;
                    count_n = '0;
                    state_n = (skip_len != 16'd0) ? SKIP : CAPTURE;
                end
                SKIP: if (clk_en) begin
                    skip_n  = skip_cnt - 16'd1;
                    state_n = (skip_cnt == 16'd1) ? CAPTURE : SKIP;
                end
                CAPTURE: if (clk_en) begin
                    wr_en   = 1'b1;
                    count_n = capture_count + 1'b1;
                    state_n = (capture_count == LAST) ? DONE : CAPTURE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            skip_cnt      <= '0;
            capture_count <= '0;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
        end else begin
            state         <= state_n;
            skip_cnt      <= skip_n;
            capture_count <= count_n;
            rd_valid      <= rd_en;
            if (rd_en)
                rd_data <= mem[rd_addr];
        end
    end

    // Buffer is never cleared; reads in the same cycle see the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[capture_count[ADDR_W-1:0]] <= sample_in;
    end
endmodule

// File: tb/tb_fir_output_capture.sv
// tb_fir_output_capture: directed scenario tasks with hand-computed expectations.
module tb_fir_output_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b0;
    logic [15:0] sample_in = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] skip_len = '0;
    logic        busy, done;
    logic [10:0] capture_count;
    logic        rd_en = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid;

    int n_checks = 0;
    int n_fail = 0;

    fir_output_capture #(.DATA_W(16), .DEPTH(1024), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .sample_in(sample_in),
        .start(start), .abort(abort), .skip_len(skip_len),
        .busy(busy), .done(done), .capture_count(capture_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [15:0] skip);
        skip_len = skip;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic rd(input logic [9:0] addr, output logic [15:0] d, output logic v);
        rd_en = 1'b1;
        rd_addr = addr;
        tick();
        d = rd_data;
        v = rd_valid;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (capture_count !== 11'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", capture_count); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        logic [15:0] d;
        logic v;
        clk_en = 1'b1;
        begin_run(16'd0);
        n = 0;
        while (busy && n < 3000) begin
            sample_in = 16'(n);
            tick();
            n++;
        end
        n_checks++; if (n !== 1024) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 1024", n); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
        n_checks++; if (capture_count !== 11'd1024) begin n_fail++; $display("FAIL basic_count: got %0d expected 1024", capture_count); end
        rd(10'd0, d, v);
        n_checks++; if (d !== 16'h0000 || v !== 1'b1) begin n_fail++; $display("FAIL basic_rd0: got %h/%b expected 0000/1", d, v); end
        rd(10'd5, d, v);
        n_checks++; if (d !== 16'h0005 || v !== 1'b1) begin n_fail++; $display("FAIL basic_rd5: got %h/%b expected 0005/1", d, v); end
        rd(10'd1023, d, v);
        n_checks++; if (d !== 16'h03FF || v !== 1'b1) begin n_fail++; $display("FAIL basic_rd1023: got %h/%b expected 03ff/1", d, v); end
        tick();
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h03FF) begin n_fail++; $display("FAIL basic_rd_hold: got %h/%b expected 03ff/0", rd_data, rd_valid); end
        n_checks++; if (done !== 1'b1 || capture_count !== 11'd1024) begin n_fail++; $display("FAIL basic_done_hold: got %b/%0d expected 1/1024", done, capture_count); end
    endtask

    task automatic test_skip();
        int n;
        logic [15:0] d;
        logic v;
        clk_en = 1'b1;
        begin_run(16'd37);
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL skip_start: got done=%b busy=%b expected 0/1", done, busy); end
        n = 0;
        while (busy && n < 3000) begin
            sample_in = 16'(n);
            tick();
            n++;
        end
        n_checks++; if (n !== 1061) begin n_fail++; $display("FAIL skip_cycles: got %0d expected 1061", n); end
        rd(10'd0, d, v);
        n_checks++; if (d !== 16'h0025) begin n_fail++; $display("FAIL skip_rd0: got %h expected 0025", d); end
        rd(10'd1023, d, v);
        n_checks++; if (d !== 16'h0424) begin n_fail++; $display("FAIL skip_rd1023: got %h expected 0424", d); end
    endtask

    task automatic test_gapped();
        int n;
        logic [15:0] d;
        logic v;
        clk_en = 1'b1;
        begin_run(16'd3);
        n = 0;
        while (busy && n < 5000) begin
            clk_en = (n % 2) == 1;
            sample_in = 16'(n);
            tick();
            n++;
        end
        clk_en = 1'b1;
        n_checks++; if (n !== 2054) begin n_fail++; $display("FAIL gapped_cycles: got %0d expected 2054", n); end
        rd(10'd0, d, v);
        n_checks++; if (d !== 16'h0007) begin n_fail++; $display("FAIL gapped_rd0: got %h expected 0007", d); end
        rd(10'd1, d, v);
        n_checks++; if (d !== 16'h0009) begin n_fail++; $display("FAIL gapped_rd1: got %h expected 0009", d); end
        rd(10'd1023, d, v);
        n_checks++; if (d !== 16'h0805) begin n_fail++; $display("FAIL gapped_rd1023: got %h expected 0805", d); end
    endtask

    task automatic test_abort();
        int n;
        logic [15:0] d;
        logic v;
        clk_en = 1'b1;
        begin_run(16'd0);
        for (int i = 0; i < 100; i++) begin
            sample_in = 16'h1000 + 16'(i);
            start = (i == 50);
            skip_len = 16'd5;
            tick();
        end
        start = 1'b0;
        n_checks++; if (capture_count !== 11'd100 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_midstart_ignored: got count=%0d busy=%b expected 100/1", capture_count, busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_state: got busy=%b done=%b expected 0/0", busy, done); end
        n_checks++; if (capture_count !== 11'd100) begin n_fail++; $display("FAIL abort_count: got %0d expected 100", capture_count); end
        tick();
        n_checks++; if (capture_count !== 11'd100 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_hold: got count=%0d busy=%b expected 100/0", capture_count, busy); end
        rd(10'd99, d, v);
        n_checks++; if (d !== 16'h1063) begin n_fail++; $display("FAIL abort_rd99: got %h expected 1063", d); end
        begin_run(16'd0);
        n = 0;
        while (busy && n < 3000) begin
            sample_in = 16'h8000 + 16'(n);
            tick();
            n++;
        end
        n_checks++; if (n !== 1024 || done !== 1'b1) begin n_fail++; $display("FAIL restart_run: got cycles=%0d done=%b expected 1024/1", n, done); end
        rd(10'd0, d, v);
        n_checks++; if (d !== 16'h8000) begin n_fail++; $display("FAIL restart_rd0: got %h expected 8000", d); end
        rd(10'd1023, d, v);
        n_checks++; if (d !== 16'h83FF) begin n_fail++; $display("FAIL restart_rd1023: got %h expected 83ff", d); end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || capture_count !== 11'd1024) begin n_fail++; $display("FAIL start_abort_same: got busy=%b done=%b count=%0d expected 0/0/1024", busy, done, capture_count); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] d;
        logic v;
        clk_en = 1'b1;
        begin_run(16'd0);
        for (int i = 0; i < 500; i++) begin
            sample_in = 16'h4000 + 16'(i);
            tick();
        end
        n_checks++; if (capture_count !== 11'd500) begin n_fail++; $display("FAIL rstmid_count_before: got %0d expected 500", capture_count); end
        rst = 1'b1;
        rd_en = 1'b1;
        rd_addr = 10'd0;
        sample_in = 16'hDEAD;
        tick();
        rst = 1'b0;
        rd_en = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got busy=%b done=%b expected 0/0", busy, done); end
        n_checks++; if (capture_count !== 11'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", capture_count); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_valid: got %b expected 0", rd_valid); end
        rd(10'd0, d, v);
        n_checks++; if (d !== 16'h4000 || v !== 1'b1) begin n_fail++; $display("FAIL rstmid_rd0: got %h/%b expected 4000/1", d, v); end
        rd(10'd499, d, v);
        n_checks++; if (d !== 16'h41F3) begin n_fail++; $display("FAIL rstmid_rd499: got %h expected 41f3", d); end
        rd(10'd500, d, v);
        n_checks++; if (d !== 16'h81F4) begin n_fail++; $display("FAIL rstmid_rd500: got %h expected 81f4", d); end
    endtask

    task automatic test_collision();
        clk_en = 1'b1;
        begin_run(16'd0);
        for (int i = 0; i < 10; i++) begin
            sample_in = 16'h2000 + 16'(i);
            tick();
        end
        sample_in = 16'h200A;
        rd_en = 1'b1;
        rd_addr = 10'd10;
        tick();
        n_checks++; if (rd_data !== 16'h400A || rd_valid !== 1'b1) begin n_fail++; $display("FAIL collide_old: got %h/%b expected 400a/1", rd_data, rd_valid); end
        n_checks++; if (capture_count !== 11'd11) begin n_fail++; $display("FAIL collide_count: got %0d expected 11", capture_count); end
        sample_in = 16'h200B;
        tick();
        n_checks++; if (rd_data !== 16'h200A) begin n_fail++; $display("FAIL collide_new: got %h expected 200a", rd_data); end
        rd_en = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip();
        test_gapped();
        test_abort();
        test_reset_mid_run();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
